ai_move_sequencer: RTL and testbench
====================================

Name: ai_move_sequencer

Overview:
- Bus-master controller that drives the density-search AI core over its 4-bit-address, 32-bit register interface.
- On a move request from game logic, it latches the board snapshot (fired/hits bitmaps, live-ship mask) and writes registers 1..9.
- It then starts the search (write addr 0), waits out the core's busy period, reads back the chosen cell index, validates it and returns it to the requester.
- Sits between the game FSM and the AI core; it is the only master on the core's port.

Parameters:
- TIMEOUT_CYCLES, 2048, max cycles spent in any wait state before aborting with move_err.
- BOARD_CELLS, 100, number of board cells; indices 0..BOARD_CELLS-1 are valid.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- req  in  1  move request pulse/level, sampled only in IDLE
- fired_in  in  100  cells already shot, bit i = cell i
- hits_in  in  100  unresolved hits, bit i = cell i
- ships_in  in  5  live-ship mask, bit k = ship k still afloat
- busy  out  1  high from req accept until the cycle after move_valid
- move_valid  out  1  one-cycle pulse, result ready
- move_index  out  7  chosen cell, held until next move_valid
- move_err  out  1  qualifies move_valid: timeout, index out of range, already-fired cell, or no live ships
- ai_addr  out  4  core register address
- ai_write  out  1  core write enable
- ai_read  out  1  core read enable
- ai_writedata  out  32  core write data
- ai_readdata  in  32  core read data, combinational from ai_addr/ai_read
- ai_waitrequest  in  1  core busy; writes are accepted only when low

Behaviour:
- Reset: state IDLE. busy, move_valid, move_err, ai_write and ai_read are 0. move_index, ai_addr and ai_writedata are 0. Snapshot registers and timeout counter are 0.
- Reset mid-operation aborts immediately with no bus cleanup; the core shares reset_n.
- IDLE: if req=1, latch fired_in/hits_in/ships_in and set busy=1. If the latched ships mask is 0, go to DONE with err=1 and no bus traffic; otherwise go to WAIT_RDY.
- WAIT_RDY: ai_write=0. Go to WR when ai_waitrequest=0. This covers the core's post-reset clear, about 20 cycles.
- WR: word counter n=1..9 drives ai_addr=n, ai_write=1 and the data below:
  - 1..3: fired[31:0], [63:32], [95:64]
  - 4: {28'b0, fired[99:96]}
  - 5..8: same slicing for hits
  - 9: {27'b0, ships}
  - A word completes in a cycle where ai_waitrequest=0; otherwise addr/data/write are held unchanged.
  - After word 9 completes, go to START.
- START: ai_addr=0, ai_write=1, ai_writedata=0. On ai_waitrequest=0, go to WAIT_BUSY.
- WAIT_BUSY: ai_write=0. Wait for ai_waitrequest=1 (expected the next cycle), then go to WAIT_DONE.
- WAIT_DONE: wait for ai_waitrequest=0, then go to RD.
- RD: one cycle with ai_addr=0, ai_read=1. Capture idx=ai_readdata[6:0] in the same cycle. err = (idx >= BOARD_CELLS) or fired[idx]. Go to DONE.
- DONE: move_valid=1 for exactly one cycle. move_index=idx, or 0 when err. move_err=err. Next cycle: IDLE, busy=0.
- A req held high re-triggers a new run in the first IDLE cycle.
- Timeout counter: cleared on every state change, increments in WAIT_RDY, WR, START, WAIT_BUSY and WAIT_DONE. Reaching TIMEOUT_CYCLES goes to DONE with err=1, and ai_write/ai_read drop that cycle.
- req while busy is ignored; it is not queued.
- Inputs change after latch: no effect on the current run.
- Nominal latency from req to move_valid: 1 + 9 + 1 + 1 + core search (~400) + 1 + 1 cycles.

Decomposition:
- Shared package ai_pkg:
  - register address constants AI_REG_START=0, AI_REG_FIRED0..3=1..4, AI_REG_HITS0..3=5..8, AI_REG_SHIPS=9
  - BOARD_CELLS
  - state enum {IDLE, WAIT_RDY, WR, START, WAIT_BUSY, WAIT_DONE, RD, DONE}
  - the core instantiates the same constants
- No sub-module. Word selection is a small case on the counter, inline.

Test Plan:
- Reset with the core model holding ai_waitrequest=1 for 20 cycles, then req -> no ai_write during those 20 cycles. The first write (addr 1) appears the cycle after ai_waitrequest falls. busy=1 throughout.
- Empty board, ships=5'b11111, model returns 44 -> writes are addr 1..9 in order, addr 4 data=0, addr 9 data=0x1F. Then addr 0 start and a read of addr 0. move_valid pulses once with move_index=44, move_err=0; busy drops the next cycle.
- ships_in=0 with req -> move_valid with move_err=1 within 2 cycles, zero ai_write/ai_read cycles.
- Model never lowers ai_waitrequest after start, TIMEOUT_CYCLES=64 -> move_valid with move_err=1, move_index=0, ai_write=0 afterwards.
- Model returns 100 -> move_err=1. In a second run, fired_in[37]=1 and the model returns 37 -> move_err=1.
- req pulsed again mid-run, plus ai_waitrequest stalls during word 5 -> no second run starts, word 5 addr/data stay stable across the stall, and exactly one move_valid is produced.

Source files
------------

// File: rtl/ai_pkg.sv
// Shared register map, board size and sequencer states for the density-search AI core
// and its bus master.
package ai_pkg;

  localparam logic [3:0] AI_REG_START  = 4'd0;
  localparam logic [3:0] AI_REG_FIRED0 = 4'd1;
  localparam logic [3:0] AI_REG_FIRED1 = 4'd2;
  localparam logic [3:0] AI_REG_FIRED2 = 4'd3;
  localparam logic [3:0] AI_REG_FIRED3 = 4'd4;
  localparam logic [3:0] AI_REG_HITS0  = 4'd5;
  localparam logic [3:0] AI_REG_HITS1  = 4'd6;
  localparam logic [3:0] AI_REG_HITS2  = 4'd7;
  localparam logic [3:0] AI_REG_HITS3  = 4'd8;
  localparam logic [3:0] AI_REG_SHIPS  = 4'd9;

  localparam int unsigned AI_BOARD_CELLS = 100;

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, WR, START, WAIT_BUSY, WAIT_DONE, RD, DONE
  } ai_state_t;

endpackage

// File: rtl/ai_move_sequencer.sv
// Bus master for the AI core: snapshots the board, loads registers 1..9, starts the
// search, reads back the chosen cell and validates it for the game FSM.
module ai_move_sequencer
  import ai_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2048,
  parameter int unsigned BOARD_CELLS    = AI_BOARD_CELLS
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req,
  input  logic [99:0]  fired_in,
  input  logic [99:0]  hits_in,
  input  logic [4:0]   ships_in,
  output logic         busy,
  output logic         move_valid,
  output logic [6:0]   move_index,
  output logic         move_err,
  output logic [3:0]   ai_addr,
  output logic         ai_write,
  output logic         ai_read,
  output logic [31:0]  ai_writedata,
  input  logic [31:0]  ai_readdata,
  input  logic         ai_waitrequest
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  ai_state_t       state_q, state_d;
  logic [99:0]     fired_q, hits_q;
  logic [4:0]      ships_q;
  logic [3:0]      word_q;
  logic [TW-1:0]   tcnt_q;
  logic            err_q;
  logic            counting, timeout_hit;
  logic [6:0]      rd_idx;
  logic            rd_err;
  logic            unused_readdata;

  assign unused_readdata = ^ai_readdata[31:7];
  assign rd_idx   = ai_readdata[6:0];
  assign rd_err   = ({25'b0, rd_idx} >= BOARD_CELLS) || fired_q[rd_idx];
  assign counting = (state_q == WAIT_RDY) || (state_q == WR) || (state_q == START) ||
                    (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign timeout_hit = counting && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req) state_d = (ships_in == '0) ? DONE : WAIT_RDY;
      WAIT_RDY:  if (!ai_waitrequest) state_d = WR;
      WR:        if (!ai_waitrequest && word_q == AI_REG_SHIPS) state_d = START;
      START:     if (!ai_waitrequest) state_d = WAIT_BUSY;
      WAIT_BUSY: if (ai_waitrequest) state_d = WAIT_DONE;
      WAIT_DONE: if (!ai_waitrequest) state_d = RD;
      RD:        state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (timeout_hit) state_d = DONE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fired_q    <= '0;
      hits_q     <= '0;
      ships_q    <= '0;
      word_q     <= '0;
      tcnt_q     <= '0;
      err_q      <= 1'b0;
      move_index <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        fired_q <= fired_in;
        hits_q  <= hits_in;
        ships_q <= ships_in;
      end
      if (state_q != WR)        word_q <= AI_REG_FIRED0;
      else if (!ai_waitrequest) word_q <= word_q + 4'd1;
      if (state_d != state_q)   tcnt_q <= '0;
      else if (counting)        tcnt_q <= tcnt_q + 1'b1;
      // Result is fixed on entry to DONE; every path other than RD is an error exit.
      if (state_d == DONE && state_q != DONE) begin
        if (state_q == RD) begin
          err_q      <= rd_err;
          move_index <= rd_err ? '0 : rd_idx;
        end else begin
          err_q      <= 1'b1;
          move_index <= '0;
        end
      end
    end
  end

  always_comb begin
    busy         = (state_q != IDLE);
    move_valid   = (state_q == DONE);
    move_err     = (state_q == DONE) && err_q;
    ai_addr      = '0;
    ai_write     = 1'b0;
    ai_read      = 1'b0;
    ai_writedata = '0;
    case (state_q)
      WR: begin
        ai_addr  = word_q;
        ai_write = !timeout_hit;
        case (word_q)
          AI_REG_FIRED0: ai_writedata = fired_q[31:0];
          AI_REG_FIRED1: ai_writedata = fired_q[63:32];
          AI_REG_FIRED2: ai_writedata = fired_q[95:64];
          AI_REG_FIRED3: ai_writedata = {28'b0, fired_q[99:96]};
          AI_REG_HITS0:  ai_writedata = hits_q[31:0];
          AI_REG_HITS1:  ai_writedata = hits_q[63:32];
          AI_REG_HITS2:  ai_writedata = hits_q[95:64];
          AI_REG_HITS3:  ai_writedata = {28'b0, hits_q[99:96]};
          AI_REG_SHIPS:  ai_writedata = {27'b0, ships_q};
          default:       ai_writedata = '0;
        endcase
      end
      START: begin
        ai_addr  = AI_REG_START;
        ai_write = !timeout_hit;
      end
      RD: begin
        ai_addr = AI_REG_START;
        ai_read = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ai_move_sequencer.sv
// Directed bench for ai_move_sequencer with a small behavioural AI-core model on the bus.
module tb_ai_move_sequencer;

  typedef struct {
    logic [99:0] fired;
    logic [99:0] hits;
    logic [4:0]  ships;
    logic [31:0] ret;
    logic [6:0]  exp_idx;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         req = 1'b0;
  logic [99:0]  fired_in = '0;
  logic [99:0]  hits_in = '0;
  logic [4:0]   ships_in = '0;
  logic         busy, move_valid, move_err, ai_write, ai_read;
  logic [6:0]   move_index;
  logic [3:0]   ai_addr;
  logic [31:0]  ai_writedata, ai_readdata;
  logic         ai_waitrequest = 1'b1;
  logic [31:0]  ret_val = '0;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, n_rd = 0, mv_count = 0;
  int first_low_cyc = -1, first_wr_cyc = -1, first_wr_addr = -1, rst_cyc = 0;
  int init_cycles = 20, search_cycles = 12, hang = 0, stall_left = 0;
  int m_phase = 0, m_cnt = 0;
  int stall_seen = 0, w5_bad = 0;
  logic [31:0] w5_exp = '0;
  wr_t  wr_log[$];
  vec_t vecs[8];

  ai_move_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset_n(reset_n), .req(req),
    .fired_in(fired_in), .hits_in(hits_in), .ships_in(ships_in),
    .busy(busy), .move_valid(move_valid), .move_index(move_index), .move_err(move_err),
    .ai_addr(ai_addr), .ai_write(ai_write), .ai_read(ai_read),
    .ai_writedata(ai_writedata), .ai_readdata(ai_readdata), .ai_waitrequest(ai_waitrequest)
  );

  always #5 clock = ~clock;

  assign ai_readdata = ai_read ? ret_val : 32'h0;

  // Core model: decides waitrequest on the falling edge from the master's current request.
  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      m_phase = 0; m_cnt = 0; ai_waitrequest = 1'b1;
    end else begin
      case (m_phase)
        0: if (m_cnt < init_cycles) begin ai_waitrequest = 1'b1; m_cnt++; end
           else begin m_phase = 1; ai_waitrequest = 1'b0; end
        1: begin
          if (ai_write && ai_addr == 4'd5 && stall_left > 0) begin
            ai_waitrequest = 1'b1; stall_left--;
          end else ai_waitrequest = 1'b0;
          if (!ai_waitrequest && ai_write && ai_addr == 4'd0) begin m_phase = 2; m_cnt = 0; end
        end
        default: begin
          ai_waitrequest = 1'b1; m_cnt++;
          if (hang == 0 && m_cnt >= search_cycles) m_phase = 1;
        end
      endcase
    end
  end

  // Bus monitor on the rising edge.
  initial forever begin
    @(posedge clock);
    cyc++;
    if (reset_n) begin
      if (!ai_waitrequest && first_low_cyc < 0) first_low_cyc = cyc;
      if (ai_write && first_wr_cyc < 0) begin first_wr_cyc = cyc; first_wr_addr = int'(ai_addr); end
      if (ai_write && !ai_waitrequest) wr_log.push_back('{ai_addr, ai_writedata});
      if (ai_write && ai_addr == 4'd5) begin
        if (ai_writedata !== w5_exp) w5_bad++;
        if (ai_waitrequest) stall_seen++;
      end
      if (ai_read) n_rd++;
      if (move_valid) mv_count++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input vec_t v, input int n);
    case (n)
      1: return v.fired[31:0];
      2: return v.fired[63:32];
      3: return v.fired[95:64];
      4: return {28'b0, v.fired[99:96]};
      5: return v.hits[31:0];
      6: return v.hits[63:32];
      7: return v.hits[95:64];
      8: return {28'b0, v.hits[99:96]};
      9: return {27'b0, v.ships};
      default: return 32'h0;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input string name, input bit midreq, input bit tmo);
    int waited = 0, bad_busy = 0, rd0 = n_rd, mv0 = mv_count, n_wr;
    logic [6:0] e_idx = tmo ? 7'd0 : v.exp_idx;
    logic       e_err = tmo ? 1'b1 : v.exp_err;
    wr_log.delete();
    w5_exp = v.hits[31:0]; stall_seen = 0; w5_bad = 0;
    ret_val = v.ret;
    fired_in = v.fired; hits_in = v.hits; ships_in = v.ships; req = 1'b1;
    @(negedge clock);
    req = 1'b0; fired_in = ~v.fired; hits_in = ~v.hits; ships_in = ~v.ships;
    check({name, " busy_after_req"}, busy, 1);
    while (!move_valid && waited < 600) begin
      req = (midreq && waited == 5);
      @(negedge clock);
      waited++;
      if (!busy) bad_busy++;
    end
    req = 1'b0;
    check({name, " move_valid_seen"}, move_valid, 1);
    check({name, " move_index"}, move_index, e_idx);
    check({name, " move_err"}, move_err, e_err);
    check({name, " busy_held"}, bad_busy, 0);
    if (v.ships == '0) check({name, " fast_err_latency"}, waited <= 1, 1);
    @(negedge clock);
    check({name, " busy_drop"}, busy, 0);
    check({name, " valid_one_cycle"}, move_valid, 0);
    check({name, " write_idle"}, ai_write, 0);
    check({name, " index_held"}, move_index, e_idx);
    check({name, " valid_count"}, mv_count - mv0, 1);
    check({name, " read_count"}, n_rd - rd0, (v.ships != '0 && !tmo) ? 1 : 0);
    n_wr = (v.ships != '0) ? 10 : 0;
    check({name, " write_count"}, wr_log.size(), n_wr);
    for (int k = 0; k < n_wr && k < wr_log.size(); k++) begin
      check($sformatf("%s word%0d", name, k), {wr_log[k].addr, wr_log[k].data},
            {(k < 9) ? 4'(k + 1) : 4'd0, exp_word(v, (k < 9) ? k + 1 : 0)});
    end
  endtask

  initial begin
    int wr_before, mv_before;
    foreach (vecs[i]) vecs[i] = '{'0, '0, 5'h1F, 32'd0, 7'd0, 1'b0};
    vecs[0].ret = 32'd44; vecs[0].exp_idx = 7'd44;
    vecs[1].ships = 5'h00; vecs[1].ret = 32'd44; vecs[1].exp_err = 1'b1;
    vecs[2].ret = 32'd100; vecs[2].exp_err = 1'b1;
    vecs[3].fired[37] = 1'b1; vecs[3].ret = 32'd37; vecs[3].exp_err = 1'b1;
    vecs[4].fired[37] = 1'b1; vecs[4].ret = 32'd38; vecs[4].exp_idx = 7'd38; vecs[4].ships = 5'h05;
    vecs[5].fired[0] = 1'b1; vecs[5].fired[98] = 1'b1; vecs[5].ret = 32'd99; vecs[5].exp_idx = 7'd99;
    vecs[6].ret = 32'd127; vecs[6].exp_err = 1'b1; vecs[6].ships = 5'h10;
    vecs[7].hits = {4'hA, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0};
    vecs[7].ret = 32'hABCD_0085; vecs[7].exp_idx = 7'd5; vecs[7].ships = 5'h02;

    repeat (3) @(negedge clock);
    check("rst busy", busy, 0);
    check("rst move_valid", move_valid, 0);
    check("rst move_err", move_err, 0);
    check("rst move_index", move_index, 0);
    check("rst ai_write", ai_write, 0);
    check("rst ai_read", ai_read, 0);
    check("rst ai_addr", ai_addr, 0);
    check("rst ai_writedata", ai_writedata, 0);

    @(posedge clock); #1 reset_n = 1'b1; rst_cyc = cyc;
    @(negedge clock);
    run_vec(vecs[0], "v0_empty", 1'b0, 1'b0);
    check("init first_write_after_ready", first_wr_cyc, first_low_cyc + 1);
    check("init first_write_addr", first_wr_addr, 1);
    check("init ready_stall_len", (first_low_cyc - rst_cyc) >= 20, 1);

    for (int i = 1; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i), 1'b0, 1'b0);

    stall_left = 3;
    run_vec(vecs[7], "midreq_stall", 1'b1, 1'b0);
    check("midreq_stall w5_stall_cycles", stall_seen, 3);
    check("midreq_stall w5_stable", w5_bad, 0);
    wr_before = wr_log.size(); mv_before = mv_count;
    repeat (30) @(negedge clock);
    check("midreq_stall no_rerun_writes", wr_log.size(), wr_before);
    check("midreq_stall no_rerun_valid", mv_count, mv_before);
    check("midreq_stall idle_busy", busy, 0);

    hang = 1;
    run_vec(vecs[0], "timeout", 1'b0, 1'b1);
    repeat (3) @(negedge clock);
    check("timeout write_stays_low", ai_write, 0);
    check("timeout read_stays_low", ai_read, 0);

    reset_n = 1'b0; hang = 0;
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
